div_seq_32: RTL and testbench
=============================

DIV_SEQ_32 -- requirements
Module: div_seq_32

Interface
REQ-001 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1: synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port start, input, 1: request a division; accepted only in IDLE.
REQ-004 SHALL have port X, input, 32: dividend, sampled on the accepting edge.
REQ-005 SHALL have port Y, input, 32: divisor, sampled on the accepting edge.
REQ-006 SHALL have port Q, output, 32: quotient, registered.
REQ-007 SHALL have port R, output, 32: remainder, registered.
REQ-008 SHALL have port busy, output, 1: high while a division is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse, high while Q/R are first valid.
REQ-010 SHALL have port div_zero, output, 1: set with done when Y was 0; holds until the next accepted start.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 IDLE SHALL go to RUN on an edge with start=1 and Y!=0, loading X, Y, remainder=0 and iteration count=0.
REQ-013 IDLE SHALL go directly to DONE on an edge with start=1 and Y==0.
- On that edge: Q=0xFFFFFFFF, R=X, div_zero=1.
REQ-014 RUN SHALL perform one restoring step per cycle.
- Shift {rem, quo} left by 1.
- Trial-subtract the divisor from the 33-bit partial remainder.
- If the result is non-negative, keep it and set the quotient LSB to 1.
REQ-015 RUN SHALL last exactly 32 cycles, then go to DONE.
- With start accepted at edge N, done is high in the cycle after edge N+32.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-017 busy SHALL be 1 in RUN and in DONE, and 0 in IDLE.
REQ-018 start SHALL be ignored while busy=1.
- No restart, and operands are not resampled.
- start held high through DONE is accepted only on the edge after the return to IDLE.
REQ-019 Q, R and div_zero SHALL hold their values from the DONE cycle until the next accepted start.
REQ-020 Changes to X or Y after the accepting edge SHALL NOT affect the result.
REQ-021 For all unsigned inputs with Y!=0, the result SHALL satisfy X = Q*Y + R with R < Y.
REQ-022 div_zero SHALL clear on the next accepted start.

Reset
REQ-023 With rst=1 on a clock edge, the block SHALL enter IDLE with Q=0, R=0, busy=0, done=0, div_zero=0 and the iteration count cleared.
REQ-024 rst SHALL take priority over start and over any in-progress operation.
- A division interrupted by reset produces no done pulse.
- The first start after reset deasserts is accepted normally.

Configuration
REQ-025 Macro DIV_SIGNED_EN SHALL select signed division; without it the block SHALL be unsigned only.
REQ-026 With DIV_SIGNED_EN defined, X and Y SHALL be two's-complement.
- Operand magnitudes are taken at the accepting edge.
- Signs are corrected in the RUN-to-DONE transition with no extra cycle, so latency is unchanged.
- Q truncates toward zero; R takes the sign of X.
- 0x80000000 / 0xFFFFFFFF gives Q=0x80000000, R=0.
- Divide by zero gives Q=0xFFFFFFFF, R=X, div_zero=1.
REQ-027 Without DIV_SIGNED_EN, the block SHALL contain no sign-handling logic and SHALL follow REQ-021.

Verification
REQ-028 Basic: start with X=100, Y=7 at edge N -> done=1 after edge N+32 with Q=14, R=2, div_zero=0, busy=0 the following cycle.
REQ-029 Divide by zero: X=0x12345678, Y=0 -> done the cycle after the accepting edge with Q=0xFFFFFFFF, R=0x12345678, div_zero=1.
REQ-030 Extremes: X=0xFFFFFFFF, Y=1 -> Q=0xFFFFFFFF, R=0; X=5, Y=9 -> Q=0, R=5.
REQ-031 Start while busy: start again at cycle 10 of RUN with new operands -> original result unchanged, exactly one done pulse.
REQ-032 Reset mid-operation: rst at cycle 20 of RUN -> next cycle busy=0, Q=R=0, no done; a new start of 9/3 -> Q=3, R=0.
REQ-033 Signed (DIV_SIGNED_EN only): X=0xFFFFFFF9 (-7), Y=2 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1) at the same latency.

Source files
------------

// File: rtl/div_seq_32.sv
// Sequential 32/32 restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement operands (default: unsigned).
module div_seq_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic [31:0] x_ld;
  logic [31:0] y_ld;
`ifdef DIV_SIGNED_EN
  logic        neg_q;
  logic        neg_r;
`endif

  // One restoring step: shift, trial-subtract, keep if non-negative
  always_comb begin
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - {1'b0, dvs};
    if (diff[32]) begin
      rem_nx = rem_sh[31:0];
      quo_nx = {quo[30:0], 1'b0};
    end else begin
      rem_nx = diff[31:0];
      quo_nx = {quo[30:0], 1'b1};
    end
  end

  // Operand magnitudes at load, sign fix-up folded into the last step
  always_comb begin
`ifdef DIV_SIGNED_EN
    x_ld  = X[31] ? (~X + 32'd1) : X;
    y_ld  = Y[31] ? (~Y + 32'd1) : Y;
    q_fin = neg_q ? (~quo_nx + 32'd1) : quo_nx;
    r_fin = neg_r ? (~rem_nx + 32'd1) : rem_nx;
`else
    x_ld  = X;
    y_ld  = Y;
    q_fin = quo_nx;
    r_fin = rem_nx;
`endif
  end

  // Control FSM with registered result and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvs      <= 32'd0;
      Q        <= 32'd0;
      R        <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            cnt  <= 5'd0;
            if (Y == 32'd0) begin
              state    <= DONE;
              Q        <= 32'hFFFF_FFFF;
              R        <= X;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state    <= RUN;
              rem      <= 32'd0;
              quo      <= x_ld;
              dvs      <= y_ld;
              div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
              neg_q    <= X[31] ^ Y[31];
              neg_r    <= X[31];
`endif
            end
          end
        end
        RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DONE;
            Q     <= q_fin;
            R     <= r_fin;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_32.sv
// Self-checking bench for div_seq_32: directed corner cases plus
// random operands against an arithmetic reference model.
module tb_div_seq_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq_32 dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .X(x),
    .Y(y),
    .Q(q),
    .R(r),
    .busy(busy),
    .done(done),
    .div_zero(div_zero)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eq, output logic [31:0] er);
`ifdef DIV_SIGNED_EN
    longint sa;
    longint sb;
`endif
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
`else
      eq = a / b;
      er = a % b;
`endif
    end
  endtask

  // Wait (bounded) for done, counting cycles after the accepting edge
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    int lat;
    ref_div(a, b, eq, er);
    start = 1'b1; x = a; y = b;
    @(posedge clk); #1;
    start = 1'b0; x = $urandom; y = $urandom;
    check({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, " lat"}, 32'(lat), (b == 32'd0) ? 32'd0 : 32'd32);
    check({tag, " Q"}, q, eq);
    check({tag, " R"}, r, er);
    check({tag, " dz"}, 32'(div_zero), 32'(b == 32'd0));
    @(posedge clk); #1;
    check({tag, " done1"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    check({tag, " Qhold"}, q, eq);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst Q", q, 32'd0);
    check("rst R", r, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst dz", 32'(div_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, "basic");
    run_op(32'h1234_5678, 32'd0, "divzero");
    run_op(32'hFFFF_FFFF, 32'd1, "max/1");
    run_op(32'd5, 32'd9, "5/9");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, "min/m1");
`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, "neg7/2");
`endif

    // Start while busy: second request ignored until back in IDLE
    start = 1'b1; x = 32'd1000; y = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    start = 1'b1; x = 32'd555; y = 32'd5;
    lat = 10;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    pulses++;
    check("busy lat", 32'(lat), 32'd32);
    check("busy pulses", 32'(pulses), 32'd1);
    check("busy Q", q, 32'd142);
    check("busy R", r, 32'd6);
    @(posedge clk); #1;
    check("busy done1", 32'(done), 32'd0);
    check("busy idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("busy reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(lat);
    check("held lat", 32'(lat), 32'd32);
    check("held Q", q, 32'd111);
    check("held R", r, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of RUN
    start = 1'b1; x = 32'hDEAD_BEEF; y = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst busy", 32'(busy), 32'd0);
    check("mrst Q", q, 32'd0);
    check("mrst R", r, 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    check("mrst nodone", 32'(pulses), 32'd0);
    run_op(32'd9, 32'd3, "9/3");

    // Random operands
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = (i == 3) ? 32'd0 : {16'd0, 16'($urandom)};
      endcase
      run_op(a, b, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
